// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: a small circular FIFO feeds a START/DATA/STOP
// serialiser so queued bytes leave back-to-back with no idle gap between frames.
module uart_tx_buffered #(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned FIFO_AW      = 2
) (
    input  logic               i_Clock,
    input  logic               i_Rst_n,
    input  logic               i_Tx_DV,
    input  logic [7:0]         i_Tx_Byte,
    output logic               o_Tx_Ready,
    output logic               o_Tx_Serial,
    output logic               o_Tx_Active,
    output logic               o_Tx_Done,
    output logic [FIFO_AW:0]   o_Fifo_Count
);

    localparam logic [15:0]      BitMax    = 16'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0] FullCount = (FIFO_AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e               r_state;
    state_e               w_state_next;
    logic [15:0]          r_clk_cnt;
    logic [15:0]          w_clk_cnt_next;
    logic [2:0]           r_bit_idx;
    logic [2:0]           w_bit_idx_next;
    logic [7:0]           r_shift;
    logic [7:0]           w_shift_next;

    logic [7:0]           r_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]   r_wr_ptr;
    logic [FIFO_AW-1:0]   r_rd_ptr;
    logic [FIFO_AW:0]     r_count;

    logic                 r_serial;
    logic                 r_active;
    logic                 r_done;
    logic                 w_serial_next;
    logic                 w_active_next;
    logic                 w_done_next;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_bit_end;
    logic                 w_has_data;

    assign o_Tx_Ready   = (r_count != FullCount);
    assign o_Tx_Serial  = r_serial;
    assign o_Tx_Active  = r_active;
    assign o_Tx_Done    = r_done;
    assign o_Fifo_Count = r_count;

    assign w_push     = i_Tx_DV && o_Tx_Ready;
    assign w_bit_end  = (r_clk_cnt == BitMax);
    assign w_has_data = (r_count != '0);

    // FIFO storage; contents need no reset since the count gates every read.
    always_ff @(posedge i_Clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_Tx_Byte;
        end
    end

    // FIFO pointers and occupancy; push and pop on the same edge cancel in the count.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // State register plus serialiser datapath and registered line outputs.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state   <= StIdle;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_serial  <= 1'b1;
            r_active  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_clk_cnt <= w_clk_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_serial  <= w_serial_next;
            r_active  <= w_active_next;
            r_done    <= w_done_next;
        end
    end

    // Next-state logic; STOP pops straight into START so frames stay contiguous.
    always_comb begin
        w_state_next   = r_state;
        w_clk_cnt_next = r_clk_cnt;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_pop          = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_has_data) begin
                    w_pop          = 1'b1;
                    w_shift_next   = r_mem[r_rd_ptr];
                    w_clk_cnt_next = '0;
                    w_state_next   = StStart;
                end
            end
            StStart: begin
                if (w_bit_end) begin
                    w_clk_cnt_next = '0;
                    w_bit_idx_next = '0;
                    w_state_next   = StData;
                end else begin
                    w_clk_cnt_next = r_clk_cnt + 16'd1;
                end
            end
            StData: begin
                if (w_bit_end) begin
                    w_clk_cnt_next = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = StStop;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_clk_cnt_next = r_clk_cnt + 16'd1;
                end
            end
            StStop: begin
                if (w_bit_end) begin
                    w_clk_cnt_next = '0;
                    if (w_has_data) begin
                        w_pop        = 1'b1;
                        w_shift_next = r_mem[r_rd_ptr];
                        w_state_next = StStart;
                    end else begin
                        w_state_next = StIdle;
                    end
                end else begin
                    w_clk_cnt_next = r_clk_cnt + 16'd1;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Output decode from the next state so registered outputs align with the state.
    always_comb begin
        w_serial_next = 1'b1;
        unique case (w_state_next)
            StStart: w_serial_next = 1'b0;
            StData:  w_serial_next = w_shift_next[w_bit_idx_next];
            default: w_serial_next = 1'b1;
        endcase
        w_active_next = (w_state_next != StIdle);
        w_done_next   = (r_state == StStop) && w_bit_end;
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench: two instances (4 and 87 clocks per bit) with per-cycle frame checks.
module tb_uart_tx_buffered;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dv_a, dv_b;
    logic [7:0] byte_a, byte_b;
    logic       ready_a, ready_b, ser_a, ser_b, act_a, act_b, done_a, done_b;
    logic [2:0] cnt_a, cnt_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_tx_buffered #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .FIFO_AW(2)) u_dut_a (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_DV(dv_a), .i_Tx_Byte(byte_a),
        .o_Tx_Ready(ready_a), .o_Tx_Serial(ser_a), .o_Tx_Active(act_a),
        .o_Tx_Done(done_a), .o_Fifo_Count(cnt_a)
    );

    uart_tx_buffered #(.CLKS_PER_BIT(87), .FIFO_DEPTH(4), .FIFO_AW(2)) u_dut_b (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_DV(dv_b), .i_Tx_Byte(byte_b),
        .o_Tx_Ready(ready_b), .o_Tx_Serial(ser_b), .o_Tx_Active(act_b),
        .o_Tx_Done(done_b), .o_Fifo_Count(cnt_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic cur_ser(input bit sel);
        return sel ? ser_b : ser_a;
    endfunction

    function automatic logic cur_act(input bit sel);
        return sel ? act_b : act_a;
    endfunction

    function automatic logic cur_done(input bit sel);
        return sel ? done_b : done_a;
    endfunction

    // One write strobe, presented from a falling edge; returns on the next falling edge.
    task automatic wr(input bit sel, input logic [7:0] b);
        if (sel) begin
            dv_b   = 1'b1;
            byte_b = b;
        end else begin
            dv_a   = 1'b1;
            byte_a = b;
        end
        @(negedge clk);
        dv_a = 1'b0;
        dv_b = 1'b0;
    endtask

    // Waits for a start bit, then checks every cycle of one frame against exp.
    // Returns on the falling edge right after the stop bit, where Done must be high.
    task automatic watch_frame(input bit sel, input logic [7:0] exp, input string tag,
                               output int waited);
        int         cpb;
        logic [9:0] bits;
        logic [7:0] rx;
        int         lvl_err, act_err, done_err;
        logic       s;
        cpb      = sel ? 87 : 4;
        bits     = {1'b1, exp, 1'b0};
        rx       = '0;
        lvl_err  = 0;
        act_err  = 0;
        done_err = 0;
        waited   = 0;
        while (cur_ser(sel) !== 1'b0 && waited < 200 * cpb) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200 * cpb) begin
            check_eq({tag, " start timeout"}, 32'(cur_ser(sel)), 32'd0);
            return;
        end
        for (int c = 0; c < 10 * cpb; c++) begin
            s = cur_ser(sel);
            if (s !== bits[c / cpb]) lvl_err++;
            if (cur_act(sel) !== 1'b1) act_err++;
            if (c > 0 && cur_done(sel) !== 1'b0) done_err++;
            if (c >= cpb && c < 9 * cpb && (c % cpb) == cpb / 2) rx[c / cpb - 1] = s;
            @(negedge clk);
        end
        check_eq({tag, " byte"}, 32'(rx), 32'(exp));
        check_eq({tag, " level errs"}, lvl_err, 0);
        check_eq({tag, " active errs"}, act_err, 0);
        check_eq({tag, " early done"}, done_err, 0);
        check_eq({tag, " done at end"}, 32'(cur_done(sel)), 32'd1);
    endtask

    initial begin
        int w;
        int peak, ready_min, idle_err;
        logic [2:0] ov_cnt [5];
        logic       ov_rdy [5];
        logic [7:0] burst [4];
        logic [7:0] loop_b [4];
        burst  = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
        loop_b = '{8'h00, 8'h7E, 8'h81, 8'hFF};

        rst_n  = 1'b0;
        dv_a   = 1'b0;
        dv_b   = 1'b0;
        byte_a = '0;
        byte_b = '0;
        repeat (3) @(negedge clk);
        check_eq("rst serial", 32'(ser_a), 32'd1);
        check_eq("rst active", 32'(act_a), 32'd0);
        check_eq("rst done", 32'(done_a), 32'd0);
        check_eq("rst count", 32'(cnt_a), 32'd0);
        check_eq("rst ready", 32'(ready_a), 32'd1);
        check_eq("rst serial b", 32'(ser_b), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single byte: popped one edge after the write, 40-cycle frame.
        wr(0, 8'h55);
        check_eq("single count after write", 32'(cnt_a), 32'd1);
        watch_frame(0, 8'h55, "single", w);
        check_eq("single latency", w, 1);
        check_eq("single active after", 32'(act_a), 32'd0);
        check_eq("single count after", 32'(cnt_a), 32'd0);

        // Burst of four consecutive writes.
        peak      = 0;
        ready_min = 1;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    wr(0, burst[i]);
                    if (int'(cnt_a) > peak) peak = int'(cnt_a);
                    if (ready_a !== 1'b1) ready_min = 0;
                end
            end
            begin
                watch_frame(0, burst[0], "burst0", w);
                check_eq("burst0 latency", w, 2);
                for (int i = 1; i < 4; i++) begin
                    watch_frame(0, burst[i], "burstN", w);
                    check_eq("burst contiguous", w, 0);
                end
            end
        join
        check_eq("burst peak count", peak, 3);
        check_eq("burst ready held", ready_min, 1);
        check_eq("burst active after", 32'(act_a), 32'd0);

        // Overflow: five writes during a frame, the fifth is dropped.
        fork
            begin
                wr(0, 8'hEE);
                repeat (5) @(negedge clk);
                for (int i = 0; i < 5; i++) begin
                    wr(0, 8'(i + 1));
                    ov_cnt[i] = cnt_a;
                    ov_rdy[i] = ready_a;
                end
            end
            begin
                watch_frame(0, 8'hEE, "ovf head", w);
                for (int i = 0; i < 4; i++) begin
                    watch_frame(0, 8'(i + 1), "ovf queued", w);
                    check_eq("ovf contiguous", w, 0);
                end
            end
        join
        check_eq("ovf count at 3rd", 32'(ov_cnt[2]), 32'd3);
        check_eq("ovf ready at 3rd", 32'(ov_rdy[2]), 32'd1);
        check_eq("ovf count full", 32'(ov_cnt[3]), 32'd4);
        check_eq("ovf ready full", 32'(ov_rdy[3]), 32'd0);
        check_eq("ovf count dropped", 32'(ov_cnt[4]), 32'd4);
        idle_err = 0;
        repeat (60) begin
            @(negedge clk);
            if (act_a !== 1'b0 || ser_a !== 1'b1) idle_err++;
        end
        check_eq("ovf no 5th frame", idle_err, 0);

        // Write landing on the STOP pop edge.
        fork
            begin
                wr(0, 8'h11);
                wr(0, 8'h22);
                repeat (39) @(negedge clk);
                check_eq("simul count pre", 32'(cnt_a), 32'd1);
                dv_a   = 1'b1;
                byte_a = 8'h77;
                @(negedge clk);
                dv_a = 1'b0;
                check_eq("simul count post", 32'(cnt_a), 32'd1);
            end
            begin
                watch_frame(0, 8'h11, "simul a", w);
                watch_frame(0, 8'h22, "simul b", w);
                check_eq("simul b contiguous", w, 0);
                watch_frame(0, 8'h77, "simul c", w);
                check_eq("simul c contiguous", w, 0);
            end
        join
        repeat (5) @(negedge clk);

        // Reset during data bit 3 with two bytes queued.
        wr(0, 8'hF0);
        wr(0, 8'h5A);
        wr(0, 8'hC3);
        repeat (16) @(negedge clk);
        check_eq("midrst serial before", 32'(ser_a), 32'd0);
        check_eq("midrst count before", 32'(cnt_a), 32'd2);
        rst_n = 1'b0;
        #1;
        check_eq("midrst serial", 32'(ser_a), 32'd1);
        check_eq("midrst count", 32'(cnt_a), 32'd0);
        check_eq("midrst active", 32'(act_a), 32'd0);
        check_eq("midrst ready", 32'(ready_a), 32'd1);
        @(negedge clk);
        rst_n    = 1'b1;
        idle_err = 0;
        repeat (100) begin
            @(negedge clk);
            if (act_a !== 1'b0 || ser_a !== 1'b1 || cnt_a !== 3'd0) idle_err++;
        end
        check_eq("midrst stays idle", idle_err, 0);

        // Slow instance: mid-bit sampling recovers each byte in order.
        fork
            begin
                for (int i = 0; i < 4; i++) wr(1, loop_b[i]);
            end
            begin
                for (int i = 0; i < 4; i++) watch_frame(1, loop_b[i], "loop", w);
            end
        join
        check_eq("loop active after", 32'(act_b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
